wb_arbiter: RTL and testbench

Writeback arbiter that sits directly upstream of the register file write port. It merges two result sources into the single port: the single-cycle ALU writeback and a long-latency unit (loads, multiply/divide) that uses a valid/ready handshake. Long-latency results are buffered in a small FIFO, writes to register 0 are discarded, and a per-register pending vector is exported so decode can stall on outstanding writes. Outputs are registered and drive the register file's `write_reg`, `write_data` and `write_enable` directly.

---
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter feeding the register file write port.
// Merges the single-cycle ALU result with long-latency results buffered in a
// DEPTH-entry FIFO. Writes to register 0 are dropped. A pending vector marks
// registers targeted by queued entries so decode can stall on them.
// Optional feature: define WB_ARBITER_BYPASS_EN to let a long-latency result
// skip the FIFO when the port is otherwise idle and the FIFO is empty.
`timescale 1ns/1ps

module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_we,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    output logic                     alu_stall,
    input  logic                     ll_valid,
    output logic                     ll_ready,
    input  logic [4:0]               ll_reg,
    input  logic [31:0]              ll_data,
    output logic                     write_enable,
    output logic [4:0]               write_reg,
    output logic [31:0]              write_data,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // FIFO storage (data path, no reset) and per-slot occupancy flags
    logic [4:0]       fifo_reg_q  [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [DEPTH-1:0] slot_vld_q, slot_vld_d;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        write_enable_q, write_enable_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] write_data_q, write_data_d;

    logic full, empty, alu_qual, ll_accept, push, pop, bypass;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign alu_qual  = alu_we && (alu_reg != 5'd0);
    // ll_ready is a function of state only; forced low while reset is held
    assign ll_ready  = rst_n && !full;
    assign alu_stall = full;
    assign ll_accept = ll_valid && ll_ready;
    assign push      = ll_accept && (ll_reg != 5'd0) && !bypass;

    assign write_enable = write_enable_q;
    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;
    assign fifo_count   = count_q;

    // Write-port source selection: full FIFO, then ALU, then FIFO, then bypass
    always_comb begin
        pop            = 1'b0;
        bypass         = 1'b0;
        write_enable_d = 1'b0;
        write_reg_d    = write_reg_q;
        write_data_d   = write_data_q;
        if (full) begin
            pop            = 1'b1;
            write_enable_d = 1'b1;
            write_reg_d    = fifo_reg_q[rd_ptr_q];
            write_data_d   = fifo_data_q[rd_ptr_q];
        end else if (alu_qual) begin
            write_enable_d = 1'b1;
            write_reg_d    = alu_reg;
            write_data_d   = alu_data;
        end else if (!empty) begin
            pop            = 1'b1;
            write_enable_d = 1'b1;
            write_reg_d    = fifo_reg_q[rd_ptr_q];
            write_data_d   = fifo_data_q[rd_ptr_q];
`ifdef WB_ARBITER_BYPASS_EN
        end else if (ll_accept && (ll_reg != 5'd0)) begin
            bypass         = 1'b1;
            write_enable_d = 1'b1;
            write_reg_d    = ll_reg;
            write_data_d   = ll_data;
`endif
        end
    end

    // FIFO pointer, occupancy and slot-valid next state
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        slot_vld_d = slot_vld_q;
        if (pop) begin
            rd_ptr_d             = rd_ptr_q + PTR_ONE;
            slot_vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
            slot_vld_d[wr_ptr_q] = 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pending vector: one bit per destination register of every queued entry
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld_q[i]) begin
                pending[fifo_reg_q[i]] = 1'b1;
            end
        end
    end

    // Control and output registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            slot_vld_q     <= '0;
            write_enable_q <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            slot_vld_q     <= slot_vld_d;
            write_enable_q <= write_enable_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
        end
    end

    // FIFO payload storage; validity is tracked separately by slot_vld_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg_q[wr_ptr_q]  <= ll_reg;
            fifo_data_q[wr_ptr_q] <= ll_data;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed testbench for wb_arbiter (default build, DEPTH=4).
`timescale 1ns/1ps

module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_we;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_reg;
    logic [31:0] ll_data;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    wb_arbiter #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_we       (alu_we),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .alu_stall    (alu_stall),
        .ll_valid     (ll_valid),
        .ll_ready     (ll_ready),
        .ll_reg       (ll_reg),
        .ll_data      (ll_data),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .pending      (pending),
        .fifo_count   (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Upstream ordering contract, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && alu_we && alu_reg != 5'd0) begin
            check("order_pending", {31'b0, pending[alu_reg]}, 32'd0);
            check("order_same_reg", {31'b0, ll_valid && ll_ready && ll_reg == alu_reg}, 32'd0);
        end
    end

    int          wr_exp_reg [13] = '{30, 10, 30, 11, 30, 12, 13, 14, 15, 16, 17, 18, 19};
    int          wr_exp_cnt [13] = '{1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 2, 1, 0};
    logic [31:0] exp_data;

    initial begin
        rst_n = 1'b0; alu_we = 1'b0; alu_reg = '0; alu_data = '0;
        ll_valid = 1'b0; ll_reg = '0; ll_data = '0;

        // Reset state
        #12;
        check("rst_we", {31'b0, write_enable}, 32'd0);
        check("rst_reg", {27'b0, write_reg}, 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_count", {29'b0, fifo_count}, 32'd0);
        check("rst_stall", {31'b0, alu_stall}, 32'd0);
        check("rst_ready", {31'b0, ll_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'b0, ll_ready}, 32'd1);

        // ALU only
        alu_we = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        check("alu_we", {31'b0, write_enable}, 32'd1);
        check("alu_reg", {27'b0, write_reg}, 32'd5);
        check("alu_data", write_data, 32'hDEADBEEF);
        alu_we = 1'b0;
        step();
        check("idle_we", {31'b0, write_enable}, 32'd0);
        check("idle_reg_hold", {27'b0, write_reg}, 32'd5);
        check("idle_data_hold", write_data, 32'hDEADBEEF);

        // Long-latency, no bypass
        ll_valid = 1'b1; ll_reg = 5'd7; ll_data = 32'h1234;
        check("ll_ready_empty", {31'b0, ll_ready}, 32'd1);
        step();
        check("ll_pending", pending, 32'h0000_0080);
        check("ll_count", {29'b0, fifo_count}, 32'd1);
        check("ll_no_write_yet", {31'b0, write_enable}, 32'd0);
        ll_valid = 1'b0;
        step();
        check("ll_we", {31'b0, write_enable}, 32'd1);
        check("ll_reg", {27'b0, write_reg}, 32'd7);
        check("ll_data", write_data, 32'h1234);
        check("ll_pending_clr", pending, 32'd0);
        check("ll_count_clr", {29'b0, fifo_count}, 32'd0);

        // Fill and stall: ALU wins every cycle while r1..r4 queue up
        for (int k = 1; k <= 4; k++) begin
            ll_valid = 1'b1; ll_reg = 5'(k); ll_data = 32'h100 + 32'(k);
            alu_we = 1'b1; alu_reg = 5'(20 + k); alu_data = 32'h200 + 32'(k);
            step();
            check("fill_alu_reg", {27'b0, write_reg}, 32'(20 + k));
            check("fill_count", {29'b0, fifo_count}, 32'(k));
        end
        check("full_ready", {31'b0, ll_ready}, 32'd0);
        check("full_stall", {31'b0, alu_stall}, 32'd1);
        check("full_pending", pending, 32'h0000_001E);
        ll_valid = 1'b0; alu_reg = 5'd25; alu_data = 32'h225;
        step();
        check("full_pop_we", {31'b0, write_enable}, 32'd1);
        check("full_pop_reg", {27'b0, write_reg}, 32'd1);
        check("full_pop_data", write_data, 32'h101);
        check("full_pop_count", {29'b0, fifo_count}, 32'd3);
        check("ready_after_pop", {31'b0, ll_ready}, 32'd1);
        check("stall_after_pop", {31'b0, alu_stall}, 32'd0);
        step();
        check("held_alu_reg", {27'b0, write_reg}, 32'd25);
        check("held_alu_data", write_data, 32'h225);
        check("held_alu_count", {29'b0, fifo_count}, 32'd3);
        alu_we = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            step();
            check("drain_reg", {27'b0, write_reg}, 32'(k));
            check("drain_data", write_data, 32'h100 + 32'(k));
            check("drain_count", {29'b0, fifo_count}, 32'(4 - k));
        end
        check("drain_pending", pending, 32'd0);

        // Register 0 handling
        ll_valid = 1'b1; ll_reg = 5'd9; ll_data = 32'h99;
        step();
        check("r9_count", {29'b0, fifo_count}, 32'd1);
        ll_valid = 1'b0; alu_we = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF;
        step();
        check("r0alu_we", {31'b0, write_enable}, 32'd1);
        check("r0alu_reg", {27'b0, write_reg}, 32'd9);
        check("r0alu_data", write_data, 32'h99);
        check("r0alu_count", {29'b0, fifo_count}, 32'd0);
        alu_we = 1'b0; ll_valid = 1'b1; ll_reg = 5'd0; ll_data = 32'h55;
        step();
        check("r0ll_count", {29'b0, fifo_count}, 32'd0);
        check("r0ll_we", {31'b0, write_enable}, 32'd0);
        check("r0ll_pending", pending, 32'd0);
        ll_valid = 1'b0;

        // Wrap-around: r10..r19 through the FIFO with ALU writes to r30 on edges 0,2,4
        for (int i = 0; i < 13; i++) begin
            if (i < 10) begin
                ll_valid = 1'b1; ll_reg = 5'(10 + i); ll_data = 32'hA000 + 32'(10 + i);
                check("wrap_ready", {31'b0, ll_ready}, 32'd1);
            end else begin
                ll_valid = 1'b0;
            end
            alu_we = (i < 6) && (i % 2 == 0);
            alu_reg = 5'd30; alu_data = 32'hC000 + 32'(i);
            step();
            exp_data = (wr_exp_reg[i] == 30) ? 32'hC000 + 32'(i) : 32'hA000 + 32'(wr_exp_reg[i]);
            check("wrap_we", {31'b0, write_enable}, 32'd1);
            check("wrap_reg", {27'b0, write_reg}, 32'(wr_exp_reg[i]));
            check("wrap_data", write_data, exp_data);
            check("wrap_count", {29'b0, fifo_count}, 32'(wr_exp_cnt[i]));
        end
        ll_valid = 1'b0; alu_we = 1'b0;

        // Reset mid-operation with three queued entries and an active write
        for (int k = 0; k < 3; k++) begin
            ll_valid = 1'b1; ll_reg = 5'(1 + k); ll_data = 32'h400 + 32'(k);
            alu_we = 1'b1; alu_reg = 5'd20; alu_data = 32'h300 + 32'(k);
            step();
        end
        check("pre_rst_count", {29'b0, fifo_count}, 32'd3);
        check("pre_rst_we", {31'b0, write_enable}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", {31'b0, write_enable}, 32'd0);
        check("mid_rst_reg", {27'b0, write_reg}, 32'd0);
        check("mid_rst_data", write_data, 32'd0);
        check("mid_rst_pending", pending, 32'd0);
        check("mid_rst_count", {29'b0, fifo_count}, 32'd0);
        check("mid_rst_stall", {31'b0, alu_stall}, 32'd0);
        check("mid_rst_ready", {31'b0, ll_ready}, 32'd0);
        ll_valid = 1'b0; alu_we = 1'b0;
        step();
        check("rst_held_we", {31'b0, write_enable}, 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("rel_ready", {31'b0, ll_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rel_no_write", {31'b0, write_enable}, 32'd0);
            check("rel_count", {29'b0, fifo_count}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
